// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end for the 5-stage MIPS32 pipeline.
// Issues one word-addressed fetch at a time over req/ack, buffers {pc, ir}
// in a DEPTH-entry FIFO and hands the head to decode under valid/ready.
// A redirect flushes the FIFO and restarts fetch at redirect_pc.
// Optional build macro IFQ_PERF_EN adds perf_fetched / perf_stall counters.
module ifetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              AW       = 10,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_ex,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [31:0]            if_ir,
  output logic [31:0]            if_pc,
  output logic [31:0]            if_npc,
`ifdef IFQ_PERF_EN
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_stall,
`endif
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // IDLE    : no request outstanding
  // WAIT    : request outstanding, data will be enqueued on ack
  // DISCARD : stale request outstanding (redirected), data dropped on ack
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_fpc, w_fpc_nxt;
  logic            r_req, w_req_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt, w_cnt_after;
  logic [AW-1:0]   r_mem_pc [DEPTH];
  logic [31:0]     r_mem_ir [DEPTH];
  logic            w_valid, w_deq, w_enq;
  logic [AW-1:0]   w_head_pc;

  assign w_valid     = (r_count != '0) && !redirect;
  assign w_deq       = w_valid && if_ready && enable_ex;
  assign w_enq       = (r_state == S_WAIT) && imem_ack && !redirect;
  // Occupancy once the in-flight word lands; slots are reserved at issue.
  assign w_cnt_after = r_count + CW'(1) - CW'(w_deq);
  assign w_head_pc   = r_mem_pc[r_rptr];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; redirect turns an unacked WAIT into DISCARD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (!redirect && enable_ex && (r_count < CW'(DEPTH))) w_state_nxt = S_WAIT;
      S_WAIT:
        if (imem_ack)
          w_state_nxt = (!redirect && enable_ex && (w_cnt_after < CW'(DEPTH))) ? S_WAIT : S_IDLE;
        else if (redirect)
          w_state_nxt = S_DISCARD;
      S_DISCARD:
        if (imem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next fetch PC and next request/address values.
  always_comb begin
    w_req_nxt  = (w_state_nxt != S_IDLE);
    w_addr_nxt = r_addr;
    if (r_state == S_IDLE && w_state_nxt == S_WAIT)
      w_addr_nxt = r_fpc;
    else if (r_state == S_WAIT && imem_ack && w_state_nxt == S_WAIT)
      w_addr_nxt = r_fpc + AW'(1);
    if (redirect)   w_fpc_nxt = redirect_pc;
    else if (w_enq) w_fpc_nxt = r_fpc + AW'(1);
    else            w_fpc_nxt = r_fpc;
    if (redirect)   w_count_nxt = '0;
    else            w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);
  end

  // Fetch PC and registered request interface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc  <= RESET_PC;
      r_req  <= 1'b0;
      r_addr <= RESET_PC;
    end else begin
      r_fpc  <= w_fpc_nxt;
      r_req  <= w_req_nxt;
      r_addr <= w_addr_nxt;
    end
  end

  // FIFO storage, pointers and occupancy; redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i] <= '0;
        r_mem_ir[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      if (redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_enq) begin
          r_mem_pc[r_wptr] <= r_fpc;
          r_mem_ir[r_wptr] <= imem_rdata;
          r_wptr           <= r_wptr + PW'(1);
        end
        if (w_deq) r_rptr <= r_rptr + PW'(1);
      end
    end
  end

`ifdef IFQ_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  // Fetched-word and full-queue stall counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_enq) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (enable_ex && !redirect && r_state == S_IDLE && r_count == CW'(DEPTH))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign q_count   = r_count;
  assign if_valid  = w_valid;
  assign if_ir     = w_valid ? r_mem_ir[r_rptr] : 32'd0;
  assign if_pc     = w_valid ? 32'(w_head_pc) : 32'd0;
  assign if_npc    = w_valid ? 32'(AW'(w_head_pc + AW'(1))) : 32'd0;

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch front end for the 5-stage MIPS32 pipeline. It sits directly upstream of the decode stage. It generates word-addressed fetch requests to instruction memory over a req/ack handshake and buffers returned instructions with their PC in a small FIFO. It presents them to decode under valid/ready. A redirect input flushes the buffer and restarts fetch at a new PC.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of 2, ≥2.
- AW, 10: instruction word-address width (1024-word memory).
- RESET_PC, 0: fetch PC after reset (AW bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- enable_ex  in  1  global pipeline enable.
- imem_req  out  1  fetch request; registered.
- imem_addr  out  AW  fetch word address; registered.
- imem_ack  in  1  one-cycle pulse; completes the outstanding request.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  AW  new fetch address; valid when redirect=1.
- if_valid  out  1  head entry available to decode.
- if_ready  in  1  decode accepts the head entry.
- if_ir  out  32  head instruction; 0 when if_valid=0.
- if_pc  out  32  head PC, zero-extended; 0 when if_valid=0.
- if_npc  out  32  (head PC+1) mod 2^AW, zero-extended; 0 when if_valid=0.
- q_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Internal fetch PC fpc; FIFO of {pc, ir}; FSM with states IDLE, WAIT, DISCARD.
- Only one request may be outstanding at a time. While imem_req=1, imem_addr is held stable until ack. A request is never withdrawn except by reset.
- IDLE→WAIT on a cycle with enable_ex=1, redirect=0 and count<DEPTH. The next edge sets imem_req=1 and imem_addr=fpc.
- WAIT with ack:
  - enqueue {fpc, imem_rdata}; fpc←fpc+1, wrapping mod 2^AW.
  - If enable_ex=1 and (count+1−deq)<DEPTH, stay in WAIT: req stays high with the new address.
  - Otherwise go to IDLE and drop req.
- Occupancy never exceeds DEPTH: space is reserved at issue time. Enqueue into a full queue is impossible by construction.
- Dequeue occurs when if_valid & if_ready & enable_ex. if_valid = (count≠0) & ~redirect.
- Simultaneous enqueue and dequeue leaves count unchanged. The pointers wrap modulo DEPTH.
- enable_ex=0:
  - no new issue and no dequeue;
  - an outstanding request still completes and enqueues.
- Redirect has the highest priority and ignores enable_ex:
  - queue flushed (count←0, pointers←0); any dequeue that cycle suppressed; fpc←redirect_pc.
  - If a request is outstanding and not acked in the same cycle, go to DISCARD.
  - If it is acked in the same cycle, drop the data and go to IDLE.
  - From IDLE, the next issue uses redirect_pc.
- DISCARD: req stays high at the stale address. On ack, drop the data and go to IDLE. A redirect in DISCARD only updates fpc and stays in DISCARD.
- Reset values: fpc=RESET_PC, state IDLE, imem_req=0, imem_addr=RESET_PC, q_count=0, if_valid=0, if_ir/if_pc/if_npc=0, FIFO storage 0. Reset mid-request abandons it; the memory must tolerate req dropping.

## Timing
- First req rises one edge after the first enabled edge following rst_n release.
- Ack sampled at edge N → entry visible on if_valid/if_ir after edge N (1-cycle latency).
- With ack every cycle and if_ready=1, throughput is 1 instruction/cycle.
- if_ir, if_pc and if_npc are combinational from the FIFO head. if_valid has a combinational path from redirect only.

## Configuration
- IFQ_PERF_EN defined:
  - adds outputs perf_fetched (out, 32) and perf_stall (out, 32), both reset to 0 and wrapping mod 2^32;
  - perf_fetched +1 per enqueue;
  - perf_stall +1 per cycle with enable_ex=1, redirect=0, state IDLE and count=DEPTH.
- IFQ_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, enable_ex=1, ack same cycle as each req, if_ready=1, mem[0..3]=A0..A3 → if_ir A0..A3 on consecutive cycles; if_pc 0..3; if_npc 1..4.
- if_ready=0, DEPTH=4, continuous ack → exactly 4 entries, q_count=4, imem_req low. Raise if_ready → fetch resumes at PC 4 with no loss or duplication.
- Redirect to 0x100 while WAIT and ack 3 cycles later → stale data dropped. Next req addr=0x100; first if_pc=0x100; q_count 0 during flush.
- Redirect on the same cycle as ack and a pending dequeue → no dequeue, data dropped, q_count=0, next addr=redirect_pc.
- fpc=0x3FF (AW=10) → entry if_pc=0x3FF, if_npc=0; next fetch addr=0.
- enable_ex low mid-request, ack arrives → entry enqueued, no dequeue, no new req until enable_ex=1.
